// File: rtl/img_mem_writer.sv
// Camera capture: pairs 8-bit camera bytes into RGB565 pixels and
// writes them linearly into the frame buffer, one write per pixel.
module img_mem_writer #(
  parameter int IMG_W = 320,
  parameter int IMG_H = 240,
  localparam int AW = $clog2(IMG_W*IMG_H),
  localparam int XW = $clog2(IMG_W+1),
  localparam int YW = $clog2(IMG_H+1)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          capture_en,
  input  logic          vsync,
  input  logic          href,
  input  logic [7:0]    cam_data,
  output logic          we,
  output logic [AW-1:0] wAddr,
  output logic [15:0]   wData,
  output logic          frame_done,
  output logic          capturing
);

  typedef enum logic [1:0] {
    S_SYNC,
    S_VBLANK,
    S_ACTIVE
  } state_t;

  localparam logic [XW-1:0] XMAX   = XW'(IMG_W);
  localparam logic [YW-1:0] YMAX   = YW'(IMG_H);
  localparam logic [YW-1:0] YLAST  = YW'(IMG_H-1);
  localparam logic [AW-1:0] STRIDE = AW'(IMG_W);

  state_t        state_q, state_d;
  logic          vs_q, hr_q;
  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;
  logic          ph_q, ph_d;
  logic [7:0]    hi_q, hi_d;
  logic [AW-1:0] base_q, base_d;
  logic          we_q, we_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [15:0]   data_q, data_d;
  logic          done_q, done_d;

  logic vs_rise, vs_fall, hr_fall;

  assign vs_rise = vsync & ~vs_q;
  assign vs_fall = ~vsync & vs_q;
  assign hr_fall = ~href & hr_q;

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    ph_d    = ph_q;
    hi_d    = hi_q;
    base_d  = base_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    data_d  = data_q;
    done_d  = 1'b0;
    unique case (state_q)
      S_SYNC: begin
        if (vsync) state_d = S_VBLANK;
      end
      S_VBLANK: begin
        if (vs_fall && capture_en) begin
          state_d = S_ACTIVE;
          x_d     = '0;
          y_d     = '0;
          ph_d    = 1'b0;
          base_d  = '0;
        end
      end
      S_ACTIVE: begin
        if (vs_rise) begin
          state_d = S_VBLANK;
          done_d  = 1'b1;
        end else if (hr_fall) begin
          // base_q tracks y*IMG_W so no multiplier is needed
          if (x_q != '0) begin
            if (y_q < YMAX)  y_d    = y_q + 1'b1;
            if (y_q < YLAST) base_d = base_q + STRIDE;
          end
          x_d  = '0;
          ph_d = 1'b0;
        end else if (href) begin
          if (!ph_q) begin
            hi_d = cam_data;
            ph_d = 1'b1;
          end else begin
            ph_d = 1'b0;
            if (x_q < XMAX) begin
              x_d = x_q + 1'b1;
              if (y_q < YMAX) begin
                we_d   = 1'b1;
                addr_d = base_q + AW'(x_q);
                data_d = {hi_q, cam_data};
              end
            end
          end
        end
      end
      default: state_d = S_SYNC;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= S_SYNC;
      vs_q    <= 1'b0;
      hr_q    <= 1'b0;
      x_q     <= '0;
      y_q     <= '0;
      ph_q    <= 1'b0;
      hi_q    <= '0;
      base_q  <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      vs_q    <= vsync;
      hr_q    <= href;
      x_q     <= x_d;
      y_q     <= y_d;
      ph_q    <= ph_d;
      hi_q    <= hi_d;
      base_q  <= base_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      done_q  <= done_d;
    end
  end

  assign we         = we_q;
  assign wAddr      = addr_q;
  assign wData      = data_q;
  assign frame_done = done_q;
  assign capturing  = (state_q == S_ACTIVE);

endmodule

// File: tb/tb_img_mem_writer.sv
// Bench for img_mem_writer: camera byte stimulus with a write
// scoreboard, frame_done/capturing timing and per-frame counts.
module tb_img_mem_writer;

  localparam int W  = 320;
  localparam int H  = 24;
  localparam int AW = $clog2(W*H);

  logic          clk;
  logic          reset_n;
  logic          capture_en;
  logic          vsync;
  logic          href;
  logic [7:0]    cam_data;
  logic          we;
  logic [AW-1:0] wAddr;
  logic [15:0]   wData;
  logic          frame_done;
  logic          capturing;

  img_mem_writer #(.IMG_W(W), .IMG_H(H)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .capture_en (capture_en),
    .vsync      (vsync),
    .href       (href),
    .cam_data   (cam_data),
    .we         (we),
    .wAddr      (wAddr),
    .wData      (wData),
    .frame_done (frame_done),
    .capturing  (capturing)
  );

  typedef struct {
    logic [31:0] a;
    logic [15:0] d;
  } exp_t;

  exp_t sb[$];
  int   lens[$];
  int   checks = 0;
  int   errors = 0;
  int   wr_cnt = 0;
  int   done_cnt = 0;
  logic [31:0] last_addr = 0;
  logic [31:0] first_addr = 0;
  logic [15:0] first_data = 0;
  logic prev_we = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (frame_done) done_cnt++;
    if (we) begin
      chk("we_gap", 32'(prev_we), 32'd0);
      if (wr_cnt == 0) begin
        first_addr = 32'(wAddr);
        first_data = wData;
      end
      wr_cnt++;
      last_addr = 32'(wAddr);
      if (sb.size() == 0) begin
        chk("spurious_we", 32'(we), 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("wAddr", 32'(wAddr), e.a);
        chk("wData", 32'(wData), 32'(e.d));
      end
    end
    prev_we = we;
  end

  task automatic send_line(input int n, input int y, input bit cap);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      href = 1'b1;
      cam_data = 8'((i + y) % 256);
      if (cap && (i % 2 == 1) && (i / 2 < W) && (y < H))
        sb.push_back('{a: 32'(y * W + i / 2),
                       d: {8'((i - 1 + y) % 256), 8'((i + y) % 256)}});
    end
    @(negedge clk);
    href = 1'b0;
    cam_data = 8'h00;
    @(negedge clk);
  endtask

  // Expects vsync already high; leaves vsync high after the frame.
  task automatic frame(input bit en);
    wr_cnt = 0;
    capture_en = en;
    @(negedge clk);
    vsync = 1'b0;
    @(negedge clk);
    chk("capturing_on", 32'(capturing), 32'(en));
    for (int l = 0; l < lens.size(); l++) begin
      send_line(lens[l], l, en);
      if (l == 0) capture_en = !en;
    end
    repeat (2) @(negedge clk);
    vsync = 1'b1;
    @(negedge clk);
    chk("frame_done", 32'(frame_done), 32'(en));
    chk("capturing_off", 32'(capturing), 32'd0);
    repeat (3) @(negedge clk);
    chk("sb_empty", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    reset_n = 1'b0;
    capture_en = 1'b1;
    vsync = 1'b0;
    href = 1'b0;
    cam_data = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_we", 32'(we), 32'd0);
    chk("rst_wAddr", 32'(wAddr), 32'd0);
    chk("rst_wData", 32'(wData), 32'd0);
    chk("rst_frame_done", 32'(frame_done), 32'd0);
    chk("rst_capturing", 32'(capturing), 32'd0);

    // reset released in the middle of a line of a running frame
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      href = 1'b1;
      cam_data = 8'(i + 8'h40);
      if (i == 3) reset_n = 1'b1;
    end
    @(negedge clk);
    href = 1'b0;
    send_line(20, 1, 1'b0);
    send_line(20, 2, 1'b0);
    chk("midrst_writes", 32'(wr_cnt), 32'd0);
    chk("midrst_capturing", 32'(capturing), 32'd0);
    vsync = 1'b1;
    repeat (3) @(negedge clk);
    chk("midrst_done", 32'(done_cnt), 32'd0);

    // full frame with two extra lines that must be dropped
    lens.delete();
    repeat (H + 2) lens.push_back(2 * W);
    frame(1'b1);
    chk("full_writes", 32'(wr_cnt), 32'(W * H));
    chk("full_first_addr", first_addr, 32'd0);
    chk("full_first_data", 32'(first_data), 32'h0001);
    chk("full_last_addr", last_addr, 32'(W * H - 1));

    // over-long line, 5-byte line, normal line
    lens = {700, 5, 2 * W};
    frame(1'b1);
    chk("odd_writes", 32'(wr_cnt), 32'(W + 2 + W));
    chk("odd_last_addr", last_addr, 32'(2 * W + W - 1));

    // capture disabled at frame start, enabled mid-frame
    lens = {2 * W, 2 * W};
    frame(1'b0);
    chk("frozen_writes", 32'(wr_cnt), 32'd0);

    // short frame ends after 10 lines
    lens.delete();
    repeat (10) lens.push_back(2 * W);
    frame(1'b1);
    chk("short_writes", 32'(wr_cnt), 32'(10 * W));
    chk("short_last_addr", last_addr, 32'(9 * W + W - 1));

    // next frame restarts at address 0
    lens = {4};
    frame(1'b1);
    chk("restart_writes", 32'(wr_cnt), 32'd2);
    chk("restart_first_addr", first_addr, 32'd0);
    chk("restart_last_addr", last_addr, 32'd1);

    chk("done_total", 32'(done_cnt), 32'd4);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
